multicycle_control_unit: RTL

Parametrised successor to the single-cycle opcode decoder. Sequences each instruction through fetch, decode, execute, memory and writeback states, and handshakes with a variable-latency memory via mem_ready. Adds conditional branch on the ALU zero flag, a HALT opcode, illegal-opcode trapping, a memory timeout and a retired-instruction counter. Sits between the instruction register/PC datapath and the ALU, register file and memory port.

---
 rtl/cpu_ctrl_pkg.sv | 50 +++++
 rtl/mem_wait_timer.sv | 41 ++++
 rtl/multicycle_control_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the multicycle control unit: FSM state encodings,
// the 3-bit legal opcode set, ALU operation encodings and default widths.
// No ports; import with "import cpu_ctrl_pkg::*;".
package cpu_ctrl_pkg;

  localparam int OPCODE_W_DEFAULT = 8;
  localparam int ALUOP_W_DEFAULT  = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_ADD    = 3'd2,
    OP_SUB    = 3'd3,
    OP_LOAD   = 3'd4,
    OP_STORE  = 3'd5,
    OP_BRANCH = 3'd6,
    OP_HALT   = 3'd7
  } opcode_e;

  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_AND  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_ADD  = 3'd3;
  localparam logic [2:0] ALU_SUB  = 3'd4;

  // ALU-class opcodes map one-to-one onto ALU operations; memory ops use ADD
  // for address generation, control ops leave the ALU idle.
  function automatic logic [2:0] alu_for_op(opcode_e op);
    case (op)
      OP_AND:             return ALU_AND;
      OP_OR:              return ALU_OR;
      OP_ADD:             return ALU_ADD;
      OP_SUB:             return ALU_SUB;
      OP_LOAD, OP_STORE:  return ALU_ADD;
      default:            return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
// Counts consecutive cycles the controller spends waiting on memory and flags
// a timeout on the cycle that would be the TIMEOUT_CYC-th wait.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   active      - controller is in a state that waits on memory
//   ready       - memory completes the access this cycle
//   clear       - controller changes state this cycle; restart the count
//   expired     - TIMEOUT_CYC-th waiting cycle with ready still low
module mem_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] count;

  // The count holds the number of waiting cycles already completed, so the
  // current cycle is the TIMEOUT_CYC-th wait when count equals TIMEOUT_CYC-1.
  // A ready on that same cycle suppresses the timeout.
  assign expired = active && !ready && (count == CW'(TIMEOUT_CYC - 1));

  // Wait counter: restarts on every state change, advances on each stalled cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (active && !ready) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Sequences each instruction through IDLE/FETCH/DECODE/EXECUTE/MEM/WB/HALT,
// handshaking with a variable-latency memory and trapping illegal opcodes and
// memory timeouts.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   run               - allows leaving IDLE and starting each fetch
//   opcode            - instruction opcode field, sampled in DECODE
//   zero              - ALU zero flag, sampled in EXECUTE
//   mem_ready         - memory completes the current access
//   ir_load, pc_inc, pc_load          - instruction register / PC controls
//   mem_sel, mem_read, mem_write      - memory port controls (sel 1 = data)
//   alu_op                            - ALU operation
//   reg_write, mem_to_reg             - register file writeback controls
//   halted, illegal, bus_error        - HALT state and sticky trap flags
//   retired                           - completed instruction count
//   state                             - current state encoding
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = OPCODE_W_DEFAULT,
  parameter int ALUOP_W     = ALUOP_W_DEFAULT,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                mem_sel,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                halted,
  output logic                illegal,
  output logic                bus_error,
  output logic [CNT_W-1:0]    retired,
  output logic [2:0]          state
);

  state_e  state_q, state_d;
  opcode_e op_q;
  logic    retire;
  logic    set_illegal;
  logic    set_bus_error;
  logic    timeout;
  logic    opcode_legal;
  logic    mem_wait_state;

  assign state = state_q;

  // Only opcodes 0..7 are defined; anything with upper bits set traps.
  assign opcode_legal   = ((opcode >> 3) == '0);
  assign mem_wait_state = (state_q == S_FETCH) || (state_q == S_MEM);

  mem_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .active (mem_wait_state),
    .ready  (mem_ready),
    .clear  (state_d != state_q),
    .expired(timeout)
  );

  // Next-state and output decode from the current state, latched opcode and
  // run. Everything defaults to idle so each state only lists what it drives.
  always_comb begin
    state_d       = state_q;
    ir_load       = 1'b0;
    pc_inc        = 1'b0;
    pc_load       = 1'b0;
    mem_sel       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    alu_op        = '0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    halted        = 1'b0;
    retire        = 1'b0;
    set_illegal   = 1'b0;
    set_bus_error = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          set_bus_error = 1'b1;
          state_d       = S_HALT;
        end
      end
      S_DECODE: begin
        if (!opcode_legal) begin
          set_illegal = 1'b1;
          state_d     = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_op = ALUOP_W'(alu_for_op(op_q));
        case (op_q)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BRANCH: begin
            pc_load = zero;
            retire  = 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
          end
          OP_HALT: begin
            retire  = 1'b1;
            state_d = S_HALT;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_sel   = 1'b1;
        mem_read  = (op_q == OP_LOAD);
        mem_write = (op_q == OP_STORE);
        if (mem_ready) begin
          if (op_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
          end
        end else if (timeout) begin
          set_bus_error = 1'b1;
          state_d       = S_HALT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LOAD);
        retire     = 1'b1;
        state_d    = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus the opcode latch, sticky trap flags and retire count.
  // The opcode is captured in DECODE so later states are immune to bus changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_AND;
      illegal   <= 1'b0;
      bus_error <= 1'b0;
      retired   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode_e'(opcode[2:0]);
      if (set_illegal)   illegal   <= 1'b1;
      if (set_bus_error) bus_error <= 1'b1;
      if (retire)        retired   <= retired + CNT_W'(1);
    end
  end

endmodule
